// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_stage                                                     |
// | Brief    : 16-bit CPU fetch stage, IF/ID register and run cycle counter    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        wb_hlt,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] pc_out,
  output logic [15:0] IF_instr,
  output logic [15:0] ID_instr,
  output logic [15:0] ID_pc_plus2,
  output logic        ID_valid,
  output logic        halt_fetched,
  output logic [15:0] cycle_cnt
);

  localparam logic [15:0] c_PC_STEP  = 16'h0002;
  localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

  logic [15:0] r_pc;
  logic [15:0] r_idInstr;
  logic [15:0] r_idPcPlus2;
  logic        r_idValid;
  logic        r_haltFetched;
  logic [15:0] r_cycleCnt;

  logic [15:0] w_pcPlus2;
  logic        w_isHalt;

  assign w_pcPlus2 = r_pc + c_PC_STEP;
  assign w_isHalt  = (imem_data[15:12] == HALT_OPCODE);

  // Priority: reset > redirect > stall > halt freeze > normal fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_idInstr     <= NOP_INSTR;
      r_idPcPlus2   <= 16'h0000;
      r_idValid     <= 1'b0;
      r_haltFetched <= 1'b0;
    end else if (redirect) begin
      r_pc          <= redirect_pc;
      r_idInstr     <= NOP_INSTR;
      r_idValid     <= 1'b0;
      r_haltFetched <= 1'b0;
    end else if (stall) begin
      r_pc          <= r_pc;
      r_idInstr     <= r_idInstr;
      r_idPcPlus2   <= r_idPcPlus2;
      r_idValid     <= r_idValid;
      r_haltFetched <= r_haltFetched;
    end else if (r_haltFetched) begin
      r_idInstr     <= NOP_INSTR;
      r_idValid     <= 1'b0;
    end else begin
      r_idInstr     <= imem_data;
      r_idPcPlus2   <= w_pcPlus2;
      r_idValid     <= 1'b1;
      // The HLT word still enters IF/ID; only the PC stops advancing.
      r_pc          <= w_isHalt ? r_pc : w_pcPlus2;
      r_haltFetched <= w_isHalt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycleCnt <= 16'h0000;
    end else if (!wb_hlt && (r_cycleCnt != c_CNT_MAX)) begin
      r_cycleCnt <= r_cycleCnt + 16'h0001;
    end
  end

  assign imem_addr    = r_pc;
  assign pc_out       = r_pc;
  assign IF_instr     = imem_data;
  assign ID_instr     = r_idInstr;
  assign ID_pc_plus2  = r_idPcPlus2;
  assign ID_valid     = r_idValid;
  assign halt_fetched = r_haltFetched;
  assign cycle_cnt    = r_cycleCnt;

endmodule
`default_nettype wire
